// File: rtl/ex_redirect_swc_if.sv
// Signal bundle between the EX stage / flush unit and the execute-stage redirect generator.
interface ex_redirect_swc_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic [3:0]       cycle_cnt;
   logic             ex_valid;
   logic             ex_br_taken;
   logic             ex_jump;
   logic             ex_trap;
   logic [PC_W-1:0]  ex_target_pc;
   logic [PC_W-1:0]  trap_vec;
   logic             flush_stall;
   logic [1:0]       flush;
   logic [1:0]       flush_tid;
   logic [PC_W-1:0]  redirect_pc;
   logic [3:0]       pend_mask;
   logic [CNT_W-1:0] redir_cnt;

   modport master (
      output cycle_cnt, ex_valid, ex_br_taken, ex_jump, ex_trap,
             ex_target_pc, trap_vec, flush_stall,
      input  flush, flush_tid, redirect_pc, pend_mask, redir_cnt
   );

   modport slave (
      input  cycle_cnt, ex_valid, ex_br_taken, ex_jump, ex_trap,
             ex_target_pc, trap_vec, flush_stall,
      output flush, flush_tid, redirect_pc, pend_mask, redir_cnt
   );
endinterface

// File: rtl/ex_redirect_swc.sv
// Execute-stage redirect generator for the 4-thread switch core: issues one-cycle
// branch/trap flush pulses and parks stalled requests in a per-thread pending slot.
module ex_redirect_swc #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input logic              hclk,
   input logic              hrstn,
   ex_redirect_swc_if.slave bus
);
   localparam logic [1:0] FL_NONE = 2'd0;
   localparam logic [1:0] FL_BR   = 2'd1;
   localparam logic [1:0] FL_TRAP = 2'd2;

   logic [1:0]       flush_q, flush_d;
   logic [1:0]       tid_q, tid_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [3:0]       pend_q, pend_d;
   logic [1:0]       pend_code_q [4];
   logic [1:0]       pend_code_d [4];
   logic [PC_W-1:0]  pend_pc_q [4];
   logic [PC_W-1:0]  pend_pc_d [4];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             slot_vld;
   logic [1:0]       t;
   logic [1:0]       req_code;
   logic [PC_W-1:0]  req_pc;
   logic             issue;

   assign slot_vld = (bus.cycle_cnt >= 4'd1) && (bus.cycle_cnt <= 4'd4);
   assign t        = 2'(bus.cycle_cnt - 4'd1);

   // Trap takes precedence over a branch/jump resolved in the same instruction.
   always_comb begin
      req_code = FL_NONE;
      req_pc   = '0;
      if (bus.ex_valid) begin
         if (bus.ex_trap) begin
            req_code = FL_TRAP;
            req_pc   = bus.trap_vec;
         end else if (bus.ex_br_taken || bus.ex_jump) begin
            req_code = FL_BR;
            req_pc   = {bus.ex_target_pc[PC_W-1:1], 1'b0};
         end
      end
   end

   always_comb begin
      flush_d     = FL_NONE;
      tid_d       = tid_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
      pend_pc_d   = pend_pc_q;
      issue       = 1'b0;
      if (slot_vld) begin
         if (pend_q[t]) begin
            // A parked request owns the slot; the current EX result is wrong-path.
            if (!bus.flush_stall) begin
               issue     = 1'b1;
               flush_d   = pend_code_q[t];
               tid_d     = t;
               pc_d      = pend_pc_q[t];
               pend_d[t] = 1'b0;
            end
         end else if (req_code != FL_NONE) begin
            if (!bus.flush_stall) begin
               issue   = 1'b1;
               flush_d = req_code;
               tid_d   = t;
               pc_d    = req_pc;
            end else begin
               pend_d[t]      = 1'b1;
               pend_code_d[t] = req_code;
               pend_pc_d[t]   = req_pc;
            end
         end
      end
      cnt_d = cnt_q;
      if (issue && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         flush_q <= FL_NONE;
         tid_q   <= '0;
         pc_q    <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            pend_code_q[i] <= FL_NONE;
            pend_pc_q[i]   <= '0;
         end
      end else begin
         flush_q     <= flush_d;
         tid_q       <= tid_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         pend_code_q <= pend_code_d;
         pend_pc_q   <= pend_pc_d;
      end
   end

   assign bus.flush       = flush_q;
   assign bus.flush_tid   = tid_q;
   assign bus.redirect_pc = pc_q;
   assign bus.pend_mask   = pend_q;
   assign bus.redir_cnt   = cnt_q;
endmodule

// File: doc/ex_redirect_swc.md
# ex_redirect_swc

Execute-stage redirect generator for the 4-thread switch core; it produces the `flush` request code consumed by the flush unit. Each cycle it samples the EX-stage result of the thread selected by `cycle_cnt` and decides whether that thread needs a branch/jump redirect or a trap redirect. It drives a one-cycle flush pulse with the thread ID and target PC. When the flush unit reports `flush_stall`, the request is parked in a per-thread pending slot and replayed on that thread's next slot.

## Interface
- `PC_W`, 32, PC / target width
- `CNT_W`, 16, width of the saturating redirect counter
- `hclk` in 1: core clock
- `hrstn` in 1: asynchronous active-low reset
- `cycle_cnt` in 4: thread slot from core top; 1..4 selects thread 0..3; 0 only after reset
- `ex_valid` in 1: EX holds a valid instruction for the slot thread
- `ex_br_taken` in 1: conditional branch resolved taken
- `ex_jump` in 1: JAL/JALR in EX
- `ex_trap` in 1: exception/ecall raised in EX
- `ex_target_pc` in PC_W: branch/jump target
- `trap_vec` in PC_W: trap vector base
- `flush_stall` in 1: flush unit busy; new flush must not issue
- `flush` out 2: 0 none, 1 branch/jump redirect, 2 trap redirect, 3 never driven
- `flush_tid` out 2: thread the flush applies to
- `redirect_pc` out PC_W: new fetch PC for `flush_tid`
- `pend_mask` out 4: per-thread pending-redirect flags
- `redir_cnt` out CNT_W: total issued redirects, saturating

## Operation
- Slot thread: t = `cycle_cnt`-1 when `cycle_cnt` is 1..4. `cycle_cnt` 0 or >4: no action, `flush`=0, state held.
- Request decode, used only when `ex_valid`=1:
  - `ex_trap` → code 2, pc=`trap_vec`
  - else `ex_br_taken`|`ex_jump` → code 1, pc=`ex_target_pc` with bit0 cleared
  - else no request
  - Trap wins over branch in the same instruction.
- Per-thread state: `pend[t]` (1b), `pend_code[t]` (2b), `pend_pc[t]` (PC_W).
- Priority per slot:
  1. `pend[t]`=1, `flush_stall`=0: issue the pending request and clear `pend[t]`. The current EX result of t is wrong-path and is discarded, even if it is a trap.
  2. `pend[t]`=1, `flush_stall`=1: hold. The EX result is discarded.
  3. `pend[t]`=0, request, `flush_stall`=0: issue immediately.
  4. `pend[t]`=0, request, `flush_stall`=1: capture into `pend[t]`/`pend_code[t]`/`pend_pc[t]`; `flush`=0.
  5. Otherwise: `flush`=0.
- Other threads' pending state is never touched on t's slot.
- `redir_cnt` increments by 1 per issue and stops at all-ones.
- `pend_mask` mirrors `pend[3:0]`.

## Timing
- All outputs are registered. An issue decided at posedge N is visible after N and lasts exactly one cycle. `flush` returns to 0 at N+1 unless another slot issues.
- Latency from EX slot to `flush` is 1 cycle when unstalled. A parked request issues on the thread's next slot with `flush_stall`=0, at minimum 4 cycles later.
- `flush_tid`/`redirect_pc` hold their last issued values when `flush`=0.
- Reset (async, at any time, including while requests are pending):
  - `flush`=0, `flush_tid`=0, `redirect_pc`=0, `pend_mask`=0, `redir_cnt`=0
  - all pending slots are cleared
- `flush_stall` is sampled at the same posedge as the slot. A stall arriving in the issue cycle does not retract a flush already registered.
- At most one flush per cycle, inherently, because one thread owns each slot.

## Test plan
- **Branch, no stall:** slot `cycle_cnt`=2, `ex_valid`=1, `ex_br_taken`=1, `ex_target_pc`=0x0000_1235.
  - Next cycle: `flush`=1, `flush_tid`=1, `redirect_pc`=0x0000_1234, `redir_cnt`=1.
  - Following cycle: `flush`=0.
- **Trap beats branch:** `cycle_cnt`=4, `ex_trap`=1, `ex_jump`=1, `trap_vec`=0x0000_0100.
  - Next cycle: `flush`=2, `flush_tid`=3, `redirect_pc`=0x100.
- **Stall park/replay:** `flush_stall`=1 on thread 0 jump to 0x200.
  - Response: `flush`=0, `pend_mask`=4'b0001.
  - On thread 0's next slot, with `flush_stall`=0 and a new trap in EX: `flush`=1, `redirect_pc`=0x200, `pend_mask`=0. The trap is discarded.
- **Independent pending:** stall held across slots 1..4, each with a jump to 0x10·k.
  - Response: `pend_mask`=4'b1111.
  - Release stall: four consecutive single-cycle flushes, tids 0,1,2,3, PCs 0x10..0x40.
- **Async reset mid-pend:** with `pend_mask`=4'b0101, drop `hrstn` between clock edges.
  - Outputs go to 0 immediately. After release, no stale flush is ever issued.
- **Counter saturation:** with `CNT_W`=4, issue 20 redirects.
  - `redir_cnt` sticks at 15.
